// File: rtl/machine_counters.sv
// machine_counters: RV32 mcycle/minstret counters with M-mode write access and user read-only aliases.
// Define MCOUNTER_OVF_FLAG_EN to add sticky wrap flags ovf_cy_out/ovf_ir_out.
module machine_counters #(
   parameter logic [11:0] MCYCLE_ADDR    = 12'hB00,
   parameter logic [11:0] MCYCLEH_ADDR   = 12'hB80,
   parameter logic [11:0] MINSTRET_ADDR  = 12'hB02,
   parameter logic [11:0] MINSTRETH_ADDR = 12'hB82,
   parameter logic [11:0] CYCLE_ADDR     = 12'hC00,
   parameter logic [11:0] CYCLEH_ADDR    = 12'hC80,
   parameter logic [11:0] INSTRET_ADDR   = 12'hC02,
   parameter logic [11:0] INSTRETH_ADDR  = 12'hC82,
   parameter logic [63:0] COUNTER_RESET  = 64'h0
) (
   input  logic        clock,
   input  logic        rst_in,
   input  logic        mcountinhibit_cy_in,
   input  logic        mcountinhibit_ir_in,
   input  logic        instret_inc_in,
   input  logic [11:0] csr_addr_in,
   input  logic        wr_en_in,
   input  logic [31:0] data_wr_in,
   input  logic        rd_en_in,
   output logic [31:0] csr_data_out,
   output logic        rd_valid_out,
   output logic        addr_hit_out,
   output logic [63:0] mcycle_out,
   output logic [63:0] minstret_out
`ifdef MCOUNTER_OVF_FLAG_EN
   ,
   output logic        ovf_cy_out,
   output logic        ovf_ir_out
`endif
);
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [31:0] csr_data_q, csr_data_d, rd_word;
   logic        rd_valid_q, rd_valid_d;
   logic        wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi, inc_cy, inc_ir;
   assign addr_hit_out = csr_addr_in == MCYCLE_ADDR || csr_addr_in == MCYCLEH_ADDR ||
                         csr_addr_in == MINSTRET_ADDR || csr_addr_in == MINSTRETH_ADDR ||
                         csr_addr_in == CYCLE_ADDR || csr_addr_in == CYCLEH_ADDR ||
                         csr_addr_in == INSTRET_ADDR || csr_addr_in == INSTRETH_ADDR;
   // A write to either half of a counter takes priority over that counter's increment.
   always_comb begin
      wr_cy_lo   = wr_en_in && csr_addr_in == MCYCLE_ADDR;
      wr_cy_hi   = wr_en_in && csr_addr_in == MCYCLEH_ADDR;
      wr_ir_lo   = wr_en_in && csr_addr_in == MINSTRET_ADDR;
      wr_ir_hi   = wr_en_in && csr_addr_in == MINSTRETH_ADDR;
      inc_cy     = !mcountinhibit_cy_in && !wr_cy_lo && !wr_cy_hi;
      inc_ir     = instret_inc_in && !mcountinhibit_ir_in && !wr_ir_lo && !wr_ir_hi;
      mcycle_d   = wr_cy_lo ? {mcycle_q[63:32], data_wr_in} :
                   wr_cy_hi ? {data_wr_in, mcycle_q[31:0]} :
                   inc_cy   ? mcycle_q + 64'd1 : mcycle_q;
      minstret_d = wr_ir_lo ? {minstret_q[63:32], data_wr_in} :
                   wr_ir_hi ? {data_wr_in, minstret_q[31:0]} :
                   inc_ir   ? minstret_q + 64'd1 : minstret_q;
      rd_word    = (csr_addr_in == MCYCLE_ADDR    || csr_addr_in == CYCLE_ADDR)    ? mcycle_q[31:0]   :
                   (csr_addr_in == MCYCLEH_ADDR   || csr_addr_in == CYCLEH_ADDR)   ? mcycle_q[63:32]  :
                   (csr_addr_in == MINSTRET_ADDR  || csr_addr_in == INSTRET_ADDR)  ? minstret_q[31:0] :
                   (csr_addr_in == MINSTRETH_ADDR || csr_addr_in == INSTRETH_ADDR) ? minstret_q[63:32] : 32'h0;
      csr_data_d = rd_en_in ? rd_word : csr_data_q;
      rd_valid_d = rd_en_in;
   end
   always_ff @(posedge clock or posedge rst_in) begin
      if (rst_in) begin
         mcycle_q   <= COUNTER_RESET;
         minstret_q <= COUNTER_RESET;
         csr_data_q <= 32'h0;
         rd_valid_q <= 1'b0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         csr_data_q <= csr_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   assign csr_data_out = csr_data_q;
   assign rd_valid_out = rd_valid_q;
   assign mcycle_out   = mcycle_q;
   assign minstret_out = minstret_q;
`ifdef MCOUNTER_OVF_FLAG_EN
   logic ovf_cy_q, ovf_cy_d, ovf_ir_q, ovf_ir_d;
   // Only an increment out of all-ones sets a flag; any high-word write clears it.
   always_comb begin
      ovf_cy_d = wr_cy_hi ? 1'b0 : (inc_cy && &mcycle_q) ? 1'b1 : ovf_cy_q;
      ovf_ir_d = wr_ir_hi ? 1'b0 : (inc_ir && &minstret_q) ? 1'b1 : ovf_ir_q;
   end
   always_ff @(posedge clock or posedge rst_in) begin
      if (rst_in) begin
         ovf_cy_q <= 1'b0;
         ovf_ir_q <= 1'b0;
      end else begin
         ovf_cy_q <= ovf_cy_d;
         ovf_ir_q <= ovf_ir_d;
      end
   end
   assign ovf_cy_out = ovf_cy_q;
   assign ovf_ir_out = ovf_ir_q;
`endif
endmodule

// File: tb/tb_machine_counters.sv
// tb_machine_counters: scenario tasks plus randomized traffic checked against a cycle-level counter model.
module tb_machine_counters;
   logic        clock = 1'b0, rst_in = 1'b0;
   logic        cy_inh = 1'b0, ir_inh = 1'b0, inc = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [11:0] addr = 12'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rvalid, hit;
   logic [63:0] mcy, mir;
   logic [63:0] m_cy = 64'h0, m_ir = 64'h0;
   logic [31:0] m_data = 32'h0;
   logic        m_valid = 1'b0, m_ovf_cy = 1'b0, m_ovf_ir = 1'b0;
   int          total = 0, bad = 0;
`ifdef MCOUNTER_OVF_FLAG_EN
   logic ovf_cy, ovf_ir;
`endif

   machine_counters dut (
      .clock(clock), .rst_in(rst_in),
      .mcountinhibit_cy_in(cy_inh), .mcountinhibit_ir_in(ir_inh),
      .instret_inc_in(inc), .csr_addr_in(addr), .wr_en_in(wr),
      .data_wr_in(wdata), .rd_en_in(rd), .csr_data_out(rdata),
      .rd_valid_out(rvalid), .addr_hit_out(hit),
      .mcycle_out(mcy), .minstret_out(mir)
`ifdef MCOUNTER_OVF_FLAG_EN
      , .ovf_cy_out(ovf_cy), .ovf_ir_out(ovf_ir)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] model_word(input logic [11:0] a);
      case (a)
         12'hB00, 12'hC00: return m_cy[31:0];
         12'hB80, 12'hC80: return m_cy[63:32];
         12'hB02, 12'hC02: return m_ir[31:0];
         12'hB82, 12'hC82: return m_ir[63:32];
         default:          return 32'h0;
      endcase
   endfunction

   function automatic logic model_hit(input logic [11:0] a);
      return a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
   endfunction

   // Advance one clock edge and update the model from the inputs presented before it.
   task automatic tick();
      logic [63:0] ncy, nir;
      logic [31:0] w;
      logic        wcy, wir, ocy, oir;
      ncy = m_cy; nir = m_ir; wcy = 1'b0; wir = 1'b0; ocy = m_ovf_cy; oir = m_ovf_ir;
      w = model_word(addr);
      if (wr) begin
         case (addr)
            12'hB00: begin ncy[31:0]  = wdata; wcy = 1'b1; end
            12'hB80: begin ncy[63:32] = wdata; wcy = 1'b1; end
            12'hB02: begin nir[31:0]  = wdata; wir = 1'b1; end
            12'hB82: begin nir[63:32] = wdata; wir = 1'b1; end
            default: ;
         endcase
      end
      if (!wcy && !cy_inh) begin
         ncy = m_cy + 64'd1;
         if (m_cy == 64'hFFFF_FFFF_FFFF_FFFF) ocy = 1'b1;
      end
      if (!wir && inc && !ir_inh) begin
         nir = m_ir + 64'd1;
         if (m_ir == 64'hFFFF_FFFF_FFFF_FFFF) oir = 1'b1;
      end
      if (wr && addr == 12'hB80) ocy = 1'b0;
      if (wr && addr == 12'hB82) oir = 1'b0;
      @(posedge clock);
      #1;
      if (rst_in) begin
         m_cy = 64'h0; m_ir = 64'h0; m_data = 32'h0; m_valid = 1'b0; m_ovf_cy = 1'b0; m_ovf_ir = 1'b0;
      end else begin
         m_cy = ncy; m_ir = nir; m_ovf_cy = ocy; m_ovf_ir = oir;
         m_valid = rd;
         if (rd) m_data = w;
      end
   endtask

   task automatic write(input logic [11:0] a, input logic [31:0] d);
      wr = 1'b1; addr = a; wdata = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; rd = 1'b1;
      tick(); tick();
      rd = 1'b0;
      total += 4;
      if (mcy !== 64'h0) begin bad++; $display("FAIL reset_mcycle got=%h exp=0", mcy); end
      if (mir !== 64'h0) begin bad++; $display("FAIL reset_minstret got=%h exp=0", mir); end
      if (rdata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rdata); end
      if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rvalid); end
      rst_in = 1'b0;
      repeat (10) tick();
      total += 2;
      if (mcy !== 64'd10) begin bad++; $display("FAIL run10_mcycle got=%0d exp=10", mcy); end
      if (mir !== 64'd0) begin bad++; $display("FAIL run10_minstret got=%0d exp=0", mir); end
      inc = 1'b1; tick(); tick(); inc = 1'b0;
      rst_in = 1'b1;
      #2;
      total += 2;
      if (mcy !== 64'h0) begin bad++; $display("FAIL async_rst_mcycle got=%h exp=0", mcy); end
      if (mir !== 64'h0) begin bad++; $display("FAIL async_rst_minstret got=%h exp=0", mir); end
      tick();
      rst_in = 1'b0;
   endtask

   task automatic test_carry();
      logic [63:0] exp_seq [3];
      exp_seq[0] = 64'h0000_0000_FFFF_FFFF;
      exp_seq[1] = 64'h0000_0001_0000_0000;
      exp_seq[2] = 64'h0000_0001_0000_0001;
      write(12'hB00, 32'hFFFF_FFFE);
      write(12'hB80, 32'h0);
      total++;
      if (mcy !== 64'h0000_0000_FFFF_FFFE) begin bad++; $display("FAIL write_no_inc got=%h exp=00000000fffffffe", mcy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (mcy !== exp_seq[i]) begin bad++; $display("FAIL carry_%0d got=%h exp=%h", i, mcy, exp_seq[i]); end
      end
      write(12'hB00, 32'hFFFF_FFFF);
      write(12'hB80, 32'hFFFF_FFFF);
      tick();
      total++;
      if (mcy !== 64'h0) begin bad++; $display("FAIL wrap64 got=%h exp=0", mcy); end
   endtask

   task automatic test_inhibit();
      logic [63:0] base, c;
      base = m_ir;
      ir_inh = 1'b1;
      repeat (5) begin inc = 1'b1; tick(); inc = 1'b0; tick(); end
      total++;
      if (mir !== base) begin bad++; $display("FAIL ir_inhibit got=%h exp=%h", mir, base); end
      ir_inh = 1'b0;
      repeat (5) begin inc = 1'b1; tick(); inc = 1'b0; tick(); end
      total++;
      if (mir !== base + 64'd5) begin bad++; $display("FAIL ir_count got=%h exp=%h", mir, base + 64'd5); end
      c = m_cy;
      cy_inh = 1'b1;
      repeat (3) tick();
      total++;
      if (mcy !== c) begin bad++; $display("FAIL cy_freeze got=%h exp=%h", mcy, c); end
      cy_inh = 1'b0;
      tick();
      total++;
      if (mcy !== c + 64'd1) begin bad++; $display("FAIL cy_resume got=%h exp=%h", mcy, c + 64'd1); end
   endtask

   task automatic test_read();
      cy_inh = 1'b1;
      write(12'hB00, 32'h1234_5678);
      write(12'hB80, 32'h0000_0007);
      rd = 1'b1; addr = 12'hC80;
      #1;
      total++;
      if (hit !== 1'b1) begin bad++; $display("FAIL hit_c80 got=%b exp=1", hit); end
      tick();
      total += 2;
      if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", rvalid); end
      if (rdata !== 32'h0000_0007) begin bad++; $display("FAIL rd_cycleh got=%h exp=00000007", rdata); end
      addr = 12'h123;
      #1;
      total++;
      if (hit !== 1'b0) begin bad++; $display("FAIL hit_123 got=%b exp=0", hit); end
      tick();
      total += 2;
      if (rdata !== 32'h0) begin bad++; $display("FAIL rd_unmatched got=%h exp=0", rdata); end
      if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_unmatched_valid got=%b exp=1", rvalid); end
      rd = 1'b0; addr = 12'hB00;
      tick();
      total += 2;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_idle_valid got=%b exp=0", rvalid); end
      if (rdata !== 32'h0) begin bad++; $display("FAIL rd_idle_hold got=%h exp=0", rdata); end
      write(12'hC00, 32'hDEAD_BEEF);
      total++;
      if (mcy !== 64'h0000_0007_1234_5678) begin bad++; $display("FAIL alias_write got=%h exp=0000000712345678", mcy); end
      cy_inh = 1'b0;
   endtask

   task automatic test_back_to_back();
      write(12'hB82, 32'h0);
      write(12'hB02, 32'd40);
      rd = 1'b1; wr = 1'b1; addr = 12'hB02; wdata = 32'd100;
      tick();
      rd = 1'b0; wr = 1'b0;
      total += 2;
      if (rdata !== 32'd40) begin bad++; $display("FAIL rw_old got=%0d exp=40", rdata); end
      if (mir[31:0] !== 32'd100) begin bad++; $display("FAIL rw_new got=%0d exp=100", mir[31:0]); end
   endtask

`ifdef MCOUNTER_OVF_FLAG_EN
   task automatic test_ovf();
      write(12'hB02, 32'hFFFF_FFFF);
      write(12'hB82, 32'hFFFF_FFFF);
      total++;
      if (ovf_ir !== 1'b0) begin bad++; $display("FAIL ovf_write_zero got=%b exp=0", ovf_ir); end
      inc = 1'b1; tick(); inc = 1'b0;
      total += 2;
      if (ovf_ir !== 1'b1) begin bad++; $display("FAIL ovf_ir_set got=%b exp=1", ovf_ir); end
      if (mir !== 64'h0) begin bad++; $display("FAIL ovf_ir_wrap got=%h exp=0", mir); end
      tick();
      total++;
      if (ovf_ir !== 1'b1) begin bad++; $display("FAIL ovf_ir_sticky got=%b exp=1", ovf_ir); end
      write(12'hB82, 32'h0);
      total++;
      if (ovf_ir !== 1'b0) begin bad++; $display("FAIL ovf_ir_clear got=%b exp=0", ovf_ir); end
      write(12'hB00, 32'hFFFF_FFFF);
      write(12'hB80, 32'hFFFF_FFFF);
      tick();
      total++;
      if (ovf_cy !== 1'b1) begin bad++; $display("FAIL ovf_cy_set got=%b exp=1", ovf_cy); end
      write(12'hB80, 32'h5);
      total++;
      if (ovf_cy !== 1'b0) begin bad++; $display("FAIL ovf_cy_clear got=%b exp=0", ovf_cy); end
   endtask
`endif

   task automatic test_random();
      logic [11:0] pool [10];
      pool = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h123, 12'hB01};
      for (int n = 0; n < 400; n++) begin
         cy_inh = ($urandom_range(3) == 0);
         ir_inh = ($urandom_range(3) == 0);
         inc    = $urandom_range(1);
         wr     = ($urandom_range(3) == 0);
         rd     = $urandom_range(1);
         addr   = ($urandom_range(7) == 0) ? 12'($urandom) : pool[$urandom_range(9)];
         wdata  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
         #1;
         total++;
         if (hit !== model_hit(addr)) begin bad++; $display("FAIL rnd_hit n=%0d addr=%h got=%b exp=%b", n, addr, hit, model_hit(addr)); end
         tick();
         total += 4;
         if (mcy !== m_cy) begin bad++; $display("FAIL rnd_mcycle n=%0d got=%h exp=%h", n, mcy, m_cy); end
         if (mir !== m_ir) begin bad++; $display("FAIL rnd_minstret n=%0d got=%h exp=%h", n, mir, m_ir); end
         if (rvalid !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rvalid, m_valid); end
         if (rdata !== m_data) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, rdata, m_data); end
`ifdef MCOUNTER_OVF_FLAG_EN
         total += 2;
         if (ovf_cy !== m_ovf_cy) begin bad++; $display("FAIL rnd_ovf_cy n=%0d got=%b exp=%b", n, ovf_cy, m_ovf_cy); end
         if (ovf_ir !== m_ovf_ir) begin bad++; $display("FAIL rnd_ovf_ir n=%0d got=%b exp=%b", n, ovf_ir, m_ovf_ir); end
`endif
      end
      cy_inh = 1'b0; ir_inh = 1'b0; inc = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_carry();
      test_inhibit();
      test_read();
      test_back_to_back();
`ifdef MCOUNTER_OVF_FLAG_EN
      test_ovf();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/machine_counters.md
Name: machine_counters

Overview:
- Implements the RV32 machine performance counters `mcycle`/`mcycleh` and `minstret`/`minstreth`, plus the read-only user shadows `cycle`/`cycleh`/`instret`/`instreth`.
- Consumes the `mcountinhibit` CY/IR bits from the counter-setup CSR block.
- Sits in the CSR file: it takes CSR reads and writes from the execute stage and the instruction-retire pulse from writeback.

Parameters:
- MCYCLE_ADDR, 12'hB00, address of mcycle (low word).
- MCYCLEH_ADDR, 12'hB80, address of mcycleh (high word).
- MINSTRET_ADDR, 12'hB02, address of minstret (low word).
- MINSTRETH_ADDR, 12'hB82, address of minstreth (high word).
- CYCLE_ADDR, 12'hC00, user read-only alias of mcycle.
- CYCLEH_ADDR, 12'hC80, user read-only alias of mcycleh.
- INSTRET_ADDR, 12'hC02, user read-only alias of minstret.
- INSTRETH_ADDR, 12'hC82, user read-only alias of minstreth.
- COUNTER_RESET, 64'h0, reset value of both counters.

Ports:
- clock, input, 1, system clock, rising edge.
- rst_in, input, 1, asynchronous active-high reset.
- mcountinhibit_cy_in, input, 1, when 1, mcycle does not increment.
- mcountinhibit_ir_in, input, 1, when 1, minstret does not increment.
- instret_inc_in, input, 1, one-cycle pulse per retired instruction.
- csr_addr_in, input, 12, CSR address.
- wr_en_in, input, 1, CSR write strobe.
- data_wr_in, input, 32, CSR write data.
- rd_en_in, input, 1, CSR read request.
- csr_data_out, output, 32, registered read data.
- rd_valid_out, output, 1, read data valid (one cycle after rd_en_in).
- addr_hit_out, output, 1, combinational: csr_addr_in matches any of the 8 addresses.
- mcycle_out, output, 64, live mcycle value.
- minstret_out, output, 64, live minstret value.

Behaviour:
- Reset (asynchronous, rst_in=1):
  - mcycle and minstret go to COUNTER_RESET.
  - csr_data_out goes to 0; rd_valid_out goes to 0.
  - Reset asserted mid-operation discards any pending write or read immediately.
- mcycle increment:
  - Each clock, mcycle <= mcycle + 1 if mcountinhibit_cy_in=0, else it holds.
  - The inhibit input takes effect on the same edge it is sampled; there is no pipeline delay.
- minstret increment:
  - Each clock, minstret <= minstret + 1 if instret_inc_in=1 and mcountinhibit_ir_in=0, else it holds.
- Arithmetic:
  - Full 64-bit add.
  - Carry from bit 31 propagates into the high word in the same cycle.
  - 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0 silently.
- Writes (wr_en_in=1, address matches an M-mode address):
  - Low-word write: bits [31:0] <= data_wr_in; bits [63:32] hold.
  - High-word write: bits [63:32] <= data_wr_in; bits [31:0] hold.
  - Write priority: a write to either half of a counter suppresses that counter's increment in that cycle. The written value is exactly what is stored; no +1 is applied after the write.
  - Writes to one counter never affect the other counter's increment.
- User alias addresses (0xC00/0xC80/0xC02/0xC82) are read-only:
  - A write to them is ignored and causes no counter change.
  - Illegal-instruction signalling is handled elsewhere.
- Reads:
  - When rd_en_in=1, csr_data_out <= the selected 32-bit word, sampled before the same-edge update (old value). rd_valid_out <= 1.
  - Latency is 1 cycle.
  - An unmatched address returns 32'h0 with rd_valid_out=1.
  - When rd_en_in=0: rd_valid_out <= 0 and csr_data_out holds.
  - Back-to-back reads are allowed every cycle.
- Simultaneous read and write to the same address: the read returns the pre-write value; the write lands on the same edge.
- Unmatched write address: no effect.

Optional Feature:
- Macro: MCOUNTER_OVF_FLAG_EN.
- When defined:
  - Adds output ports ovf_cy_out and ovf_ir_out (1 bit each, reset 0).
  - A flag sets sticky on the cycle its counter wraps from all-ones to 0 by increment. A write-induced zero does not set it.
  - A write of any value to the corresponding high-word M-mode address clears the flag. If a wrap and a clear occur in the same cycle, clear wins (no wrap happens, because the write suppresses the increment).
- When not defined: the ports are absent and no flag logic is built.

Test Plan:
- Reset, then release rst_in with both inhibit bits 0 and no instret pulses for 10 cycles -> mcycle_out = 10, minstret_out = 0. Asserting rst_in asynchronously mid-cycle clears both counters before the next edge.
- Write mcycle = 32'hFFFF_FFFE and mcycleh = 0, run 3 cycles -> mcycle_out sequence 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001. The write cycle itself does not increment.
- Set mcountinhibit_ir_in = 1 and pulse instret_inc_in 5 times -> minstret_out unchanged. Clear inhibit and pulse 5 times -> minstret_out = 5. Toggling mcountinhibit_cy_in freezes and resumes mcycle on the same edge.
- Read 0xC80 with mcycle = 64'h0000_0007_1234_5678 -> the next cycle gives rd_valid_out = 1 and csr_data_out = 32'h0000_0007. Reading 0x123 -> csr_data_out = 0 and addr_hit_out = 0. Writing 0xC00 -> mcycle unaffected.
- Same-cycle read and write of 0xB02 (old minstret low = 32'd40, write 32'd100) -> csr_data_out = 40, minstret_out low = 100.
- With MCOUNTER_OVF_FLAG_EN: load minstret to all-ones and pulse instret once -> ovf_ir_out = 1 and minstret_out = 0. Write 0xB82 -> ovf_ir_out = 0 on the next cycle.
